// File: rtl/multi_timer.sv
// multi_timer: NCH independent programmable interval timers with sticky flags, tick pulses and masked irq
module multi_timer #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4
) (
    input  logic                 timeclk,
    input  logic                 reset,
    input  logic [NCH*WIDTH-1:0] datain,
    input  logic [NCH-1:0]       start,
    input  logic [NCH-1:0]       stop,
    input  logic [NCH-1:0]       mode,
    input  logic [NCH-1:0]       hold,
    input  logic [NCH-1:0]       clr,
    input  logic [NCH-1:0]       irq_mask,
    output logic [NCH-1:0]       timeup,
    output logic [NCH-1:0]       tick,
    output logic [NCH-1:0]       busy,
    output logic [NCH*WIDTH-1:0] count,
    output logic                 irq
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [WIDTH-1:0] ONE = 1;
    genvar c;
    generate
        for (c = 0; c < NCH; c++) begin : g_ch
            state_t           state;
            logic [WIDTH-1:0] period_r;
            logic [WIDTH-1:0] cnt;
            logic             mode_r;
            logic             tick_r;
            logic             busy_r;
            logic             flag_r;
            logic             expire;
            assign expire = state == RUN && !hold[c] && !stop[c] && !start[c] && cnt == period_r;
            // channel FSM: stop beats start beats count/compare
            always_ff @(posedge timeclk or posedge reset) begin
                if (reset) begin
                    state    <= IDLE;
                    period_r <= '0;
                    mode_r   <= 1'b0;
                    cnt      <= '0;
                    tick_r   <= 1'b0;
                    busy_r   <= 1'b0;
                end else if (stop[c]) begin
                    state  <= IDLE;
                    cnt    <= '0;
                    tick_r <= 1'b0;
                    busy_r <= 1'b0;
                end else if (start[c]) begin
                    period_r <= datain[c*WIDTH +: WIDTH];
                    mode_r   <= mode[c];
                    cnt      <= '0;
                    state    <= RUN;
                    tick_r   <= 1'b0;
                    busy_r   <= 1'b1;
                end else if (state == RUN && !hold[c]) begin
                    tick_r <= expire;
                    if (!expire) cnt <= cnt + ONE;
                    else if (mode_r) cnt <= '0;
                    else begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                    end
                end else begin
                    tick_r <= 1'b0;
                end
            end
            // sticky expiry flag; a same-edge expiry overrides clr
            always_ff @(posedge timeclk or posedge reset) begin
                if (reset) flag_r <= 1'b0;
                else flag_r <= expire | (flag_r & ~clr[c]);
            end
            assign timeup[c] = flag_r;
            assign tick[c] = tick_r;
            assign busy[c] = busy_r;
            assign count[c*WIDTH +: WIDTH] = cnt;
        end
    endgenerate
    // interrupt registered from the current flags, so it trails timeup by one cycle
    always_ff @(posedge timeclk or posedge reset) begin
        if (reset) irq <= 1'b0;
        else irq <= |(timeup & irq_mask);
    end
endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: directed scoreboard bench for multi_timer tick timing, flags, hold, restart, irq and reset
module tb_multi_timer;
    logic        timeclk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] datain = '0;
    logic [3:0]  start = '0, stop = '0, mode = '0, hold = '0, clr = '0, irq_mask = '0;
    logic [3:0]  timeup, tick, busy;
    logic [63:0] count;
    logic        irq;
    logic [7:0]  d8 = '0, count8;
    logic        start8 = 1'b0, timeup8, tick8, busy8, irq8;
    int          cyc = 0;
    int          checks = 0, errors = 0;
    int          q[4][$];
    int          e, s, e2;

    multi_timer dut (
        .timeclk(timeclk), .reset(reset), .datain(datain), .start(start), .stop(stop),
        .mode(mode), .hold(hold), .clr(clr), .irq_mask(irq_mask), .timeup(timeup),
        .tick(tick), .busy(busy), .count(count), .irq(irq)
    );

    multi_timer #(.WIDTH(8), .NCH(1)) dut8 (
        .timeclk(timeclk), .reset(reset), .datain(d8), .start(start8), .stop(1'b0),
        .mode(1'b0), .hold(1'b0), .clr(1'b0), .irq_mask(1'b0), .timeup(timeup8),
        .tick(tick8), .busy(busy8), .count(count8), .irq(irq8)
    );

    always #5 timeclk = ~timeclk;

    always @(posedge timeclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // tick monitor: every tick must match the next expected edge for its channel
    always @(negedge timeclk) begin
        for (int c = 0; c < 4; c++) begin
            if (tick[c]) begin
                checks++;
                if (q[c].size() == 0) begin
                    errors++;
                    $display("FAIL tick%0d unexpected: got tick at cycle %0d expected none", c, cyc);
                end else if (q[c][0] != cyc) begin
                    errors++;
                    $display("FAIL tick%0d timing: got cycle %0d expected %0d", c, cyc, q[c][0]);
                    void'(q[c].pop_front());
                end else begin
                    void'(q[c].pop_front());
                end
            end else if (q[c].size() > 0 && q[c][0] < cyc) begin
                checks++;
                errors++;
                $display("FAIL tick%0d missing: got none expected at cycle %0d", c, q[c][0]);
                void'(q[c].pop_front());
            end
        end
    end

    task automatic start_ch(input int ch, input int p, input logic m, output int edge_no);
        datain[ch*16 +: 16] = p[15:0];
        mode[ch] = m;
        start[ch] = 1'b1;
        edge_no = cyc + 1;
        @(negedge timeclk);
        start[ch] = 1'b0;
    endtask

    initial begin
        #3;
        chk("reset timeup", 32'(timeup), 0);
        chk("reset tick", 32'(tick), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset count", 32'(count != 0), 0);
        chk("reset irq", 32'(irq), 0);
        @(negedge timeclk);
        reset = 1'b0;
        @(negedge timeclk);

        start_ch(0, 5, 1'b0, e);
        q[0].push_back(e + 6);
        chk("t1 busy running", 32'(busy[0]), 1);
        chk("t1 count start", 32'(count[15:0]), 0);
        repeat (6) @(negedge timeclk);
        chk("t1 timeup", 32'(timeup[0]), 1);
        chk("t1 busy done", 32'(busy[0]), 0);
        repeat (2) @(negedge timeclk);
        chk("t1 count holds", 32'(count[15:0]), 5);

        start_ch(1, 3, 1'b1, e);
        for (int k = 1; k <= 5; k++) q[1].push_back(e + 4 * k);
        repeat (20) @(negedge timeclk);
        stop[1] = 1'b1;
        @(negedge timeclk);
        stop[1] = 1'b0;
        chk("t2 busy after stop", 32'(busy[1]), 0);
        chk("t2 count after stop", 32'(count[31:16]), 0);
        chk("t2 timeup kept", 32'(timeup[1]), 1);
        clr[1] = 1'b1;
        @(negedge timeclk);
        clr[1] = 1'b0;
        chk("t2 timeup cleared", 32'(timeup[1]), 0);

        start_ch(2, 0, 1'b1, e);
        for (int k = 1; k <= 10; k++) q[2].push_back(e + k);
        repeat (4) @(negedge timeclk);
        clr[2] = 1'b1;
        @(negedge timeclk);
        clr[2] = 1'b0;
        chk("t3 set beats clr", 32'(timeup[2]), 1);
        repeat (5) @(negedge timeclk);
        stop[2] = 1'b1;
        @(negedge timeclk);
        stop[2] = 1'b0;
        chk("t3 busy after stop", 32'(busy[2]), 0);
        clr[2] = 1'b1;
        @(negedge timeclk);
        clr[2] = 1'b0;
        chk("t3 timeup cleared", 32'(timeup[2]), 0);

        start_ch(3, 10, 1'b0, e);
        q[3].push_back(e + 18);
        repeat (3) @(negedge timeclk);
        hold[3] = 1'b1;
        repeat (7) @(negedge timeclk);
        hold[3] = 1'b0;
        chk("t4 count frozen", 32'(count[63:48]), 3);
        chk("t4 busy in hold", 32'(busy[3]), 1);
        repeat (8) @(negedge timeclk);
        chk("t4 timeup", 32'(timeup[3]), 1);
        clr[3] = 1'b1;
        @(negedge timeclk);
        clr[3] = 1'b0;
        start_ch(3, 10, 1'b0, s);
        repeat (4) @(negedge timeclk);
        chk("t4 count before restart", 32'(count[63:48]), 4);
        start_ch(3, 2, 1'b0, e2);
        q[3].push_back(e2 + 3);
        chk("t4 count restarted", 32'(count[63:48]), 0);
        repeat (10) @(negedge timeclk);
        chk("t4 count new period", 32'(count[63:48]), 2);

        d8 = 8'd255;
        start8 = 1'b1;
        e = cyc + 1;
        @(negedge timeclk);
        start8 = 1'b0;
        for (int i = 0; i < 300 && !tick8; i++) @(negedge timeclk);
        chk("t6 tick edge", 32'(cyc), 32'(e + 256));
        chk("t6 count at tick", 32'(count8), 255);
        repeat (3) @(negedge timeclk);
        chk("t6 count no wrap", 32'(count8), 255);
        chk("t6 busy done", 32'(busy8), 0);
        chk("t6 timeup", 32'(timeup8), 1);

        clr = 4'hf;
        @(negedge timeclk);
        clr = 4'h0;
        irq_mask = 4'b0100;
        datain = {16'd100, 16'd3, 16'd100, 16'd1};
        mode = 4'b1010;
        start = 4'hf;
        e = cyc + 1;
        @(negedge timeclk);
        start = 4'h0;
        q[0].push_back(e + 2);
        q[2].push_back(e + 4);
        repeat (2) @(negedge timeclk);
        chk("t5 timeup0", 32'(timeup[0]), 1);
        chk("t5 irq masked", 32'(irq), 0);
        repeat (2) @(negedge timeclk);
        chk("t5 timeup2", 32'(timeup[2]), 1);
        chk("t5 irq lag", 32'(irq), 0);
        @(negedge timeclk);
        chk("t5 irq set", 32'(irq), 1);
        chk("t5 ch1 running", 32'(busy[1]), 1);
        #2 reset = 1'b1;
        #1;
        chk("t5 async timeup", 32'(timeup), 0);
        chk("t5 async busy", 32'(busy), 0);
        chk("t5 async count", 32'(count != 0), 0);
        chk("t5 async irq", 32'(irq), 0);
        @(negedge timeclk);
        reset = 1'b0;
        repeat (2) @(negedge timeclk);

        for (int c = 0; c < 4; c++) chk("pending ticks", 32'(q[c].size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
